// File: rtl/serial_mag_comp.sv
// Bit-serial magnitude comparator: walks both operands MSB first through
// the K/L cascade, one bit per clock, with a start/done handshake.
module serial_mag_comp #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             k,
    output logic             l
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] x_sr;
    logic [WIDTH-1:0] y_sr;
    logic [CW-1:0]    cnt;
    logic             kacc;
    logic             lacc;
    logic             smode;

    logic a;
    logic b;
    logic swap;
    logic k_nxt;
    logic l_nxt;
    logic last;
    logic finish;

    // Sign bit of a two's-complement word carries inverted weight.
    always_comb begin
        a      = x_sr[WIDTH-1];
        b      = y_sr[WIDTH-1];
        swap   = smode && (cnt == '0);
        k_nxt  = kacc;
        l_nxt  = lacc;
        if (!(kacc || lacc)) begin
            k_nxt = swap ? (~a & b) : (a & ~b);
            l_nxt = swap ? (a & ~b) : (~a & b);
        end
        last   = (cnt == CW'(WIDTH - 1));
        finish = last || (EARLY_EXIT && (k_nxt || l_nxt));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            k     <= 1'b0;
            l     <= 1'b0;
            x_sr  <= '0;
            y_sr  <= '0;
            cnt   <= '0;
            kacc  <= 1'b0;
            lacc  <= 1'b0;
            smode <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        x_sr  <= X;
                        y_sr  <= Y;
                        smode <= signed_mode;
                        kacc  <= 1'b0;
                        lacc  <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    x_sr <= {x_sr[WIDTH-2:0], 1'b0};
                    y_sr <= {y_sr[WIDTH-2:0], 1'b0};
                    cnt  <= cnt + 1'b1;
                    kacc <= k_nxt;
                    lacc <= l_nxt;
                    if (finish) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        k     <= k_nxt;
                        l     <= l_nxt;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Bench for serial_mag_comp: four instances (8/16 bit, fixed/early exit)
// scored against an arithmetic reference of result and completion cycle.
module tb_serial_mag_comp;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] x_in;
    logic [15:0] y_in;
    logic        signed_mode;
    logic [3:0]  busy_w;
    logic [3:0]  done_w;
    logic [3:0]  k_w;
    logic [3:0]  l_w;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = (g < 2) ? 8 : 16;
        serial_mag_comp #(
            .WIDTH(W),
            .EARLY_EXIT(g % 2 == 1)
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .start(start),
            .X(x_in[W-1:0]),
            .Y(y_in[W-1:0]),
            .signed_mode(signed_mode),
            .busy(busy_w[g]),
            .done(done_w[g]),
            .k(k_w[g]),
            .l(l_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int d;
        int cyc;
        bit k;
        bit l;
    } ev_t;

    ev_t q[$];
    int  n_chk  = 0;
    int  n_pass = 0;
    int  cyc    = 0;
    int  acc[4];
    int  fin[4];
    int  prev_kl[4];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    // Reference: a start seen at edge e is taken by every idle instance.
    task automatic accept(input int e, input logic [15:0] x,
                          input logic [15:0] y, input bit sm);
        for (int d = 0; d < 4; d++) begin
            int     w;
            int     n;
            longint vx;
            longint vy;
            w  = (d < 2) ? 8 : 16;
            if (e > fin[d]) begin
                vx = longint'(x) & ((longint'(1) << w) - 1);
                vy = longint'(y) & ((longint'(1) << w) - 1);
                if (sm && vx[w-1]) vx = vx - (longint'(1) << w);
                if (sm && vy[w-1]) vy = vy - (longint'(1) << w);
                n = w;
                if (d % 2 == 1)
                    for (int i = 0; i < w; i++)
                        if (x[i] != y[i]) n = w - i;
                q.push_back('{d, e + n, vx > vy, vx < vy});
                acc[d] = e;
                fin[d] = e + n;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 4; d++) begin
                if (!reset) begin
                    int idx;
                    idx = -1;
                    for (int i = q.size() - 1; i >= 0; i--)
                        if (q[i].d == d) idx = i;
                    chk($sformatf("busy[%0d]", d), int'(busy_w[d]),
                        int'(cyc >= acc[d] && cyc < fin[d]));
                    chk($sformatf("kl_excl[%0d]", d),
                        int'(k_w[d] & l_w[d]), 0);
                    if (done_w[d]) begin
                        if (idx < 0) begin
                            chk($sformatf("extra_done[%0d]", d),
                                int'(done_w[d]), 0);
                        end else begin
                            chk($sformatf("done_cyc[%0d]", d), cyc, q[idx].cyc);
                            chk($sformatf("k[%0d]", d), int'(k_w[d]), int'(q[idx].k));
                            chk($sformatf("l[%0d]", d), int'(l_w[d]), int'(q[idx].l));
                            q.delete(idx);
                        end
                    end else begin
                        chk($sformatf("kl_hold[%0d]", d),
                            int'({k_w[d], l_w[d]}), prev_kl[d]);
                        if (idx >= 0 && q[idx].cyc < cyc) begin
                            chk($sformatf("missed_done[%0d]", d),
                                int'(done_w[d]), 1);
                            q.delete(idx);
                        end
                    end
                end
                prev_kl[d] = int'({k_w[d], l_w[d]});
            end
        end
    end

    task automatic drive(input bit st, input logic [15:0] x,
                         input logic [15:0] y, input bit sm);
        @(negedge clk);
        #1;
        start       = st;
        x_in        = x;
        y_in        = y;
        signed_mode = sm;
        if (st) accept(cyc + 1, x, y, sm);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 16'($urandom), 16'($urandom),
                         1'($urandom_range(0, 1)));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"}, int'(busy_w), 0);
        chk({tag, "_done"}, int'(done_w), 0);
        chk({tag, "_k"}, int'(k_w), 0);
        chk({tag, "_l"}, int'(l_w), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        start = 1'b0;
        q.delete();
        for (int d = 0; d < 4; d++) begin
            acc[d] = 0;
            fin[d] = 0;
        end
        @(negedge clk);
        #1;
        check_cleared("rst");
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] rx;
        logic [15:0] ry;
        reset       = 1'b1;
        start       = 1'b0;
        x_in        = '0;
        y_in        = '0;
        signed_mode = 1'b0;
        for (int d = 0; d < 4; d++) begin
            acc[d]     = 0;
            fin[d]     = 0;
            prev_kl[d] = 0;
        end
        repeat (2) @(negedge clk);
        #1;
        check_cleared("init");
        reset = 1'b0;

        drive(1'b1, 16'h0080, 16'h007F, 1'b1);
        idle(20);
        drive(1'b1, 16'h00A5, 16'h00A4, 1'b0);
        idle(20);
        drive(1'b1, 16'h0080, 16'h007F, 1'b0);
        idle(20);
        drive(1'b1, 16'h003C, 16'h003C, 1'b1);
        idle(20);
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b1);
        idle(20);
        drive(1'b1, 16'h0000, 16'hFFFF, 1'b1);
        idle(20);

        drive(1'b1, 16'h1234, 16'h1234, 1'b0);
        idle(3);
        do_reset();
        idle(20);
        drive(1'b1, 16'h00F0, 16'h000F, 1'b0);
        idle(20);

        drive(1'b1, 16'h5A5A, 16'h5A5A, 1'b0);
        idle(2);
        drive(1'b1, 16'h0001, 16'hFFFF, 1'b1);
        idle(20);

        repeat (40) drive(1'b1, 16'($urandom), 16'($urandom),
                          1'($urandom_range(0, 1)));
        idle(20);

        repeat (80) begin
            rx = 16'($urandom);
            if ($urandom_range(0, 3) == 0)
                ry = rx ^ (16'(1) << $urandom_range(0, 15));
            else if ($urandom_range(0, 7) == 0)
                ry = rx;
            else
                ry = 16'($urandom);
            drive(1'b1, rx, ry, 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 18));
        end
        idle(20);

        chk("pending", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
